seg_display_sched: RTL and testbench

Two-requester scheduler for the single 7-segment output pad group (`uo_out`). It arbitrates between two character-stream sources at message granularity using round-robin order, and paces each character with a programmable dwell time. An optional blank gap separates consecutive characters so that repeated letters (e.g. "L","L") stay distinguishable. The block sits between the letter sources and the top-level `uo_out` assignment.

---
 rtl/seg_sched_pkg.sv | 28 ++
 rtl/seg_rr_arbiter.sv | 22 ++
 rtl/seg_display_sched.sv | 119 +++++++++++
 tb/tb_seg_display_sched.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the two-source 7-segment display scheduler.
// The BLANK state encoding exists only when SEG_SCHED_BLANK_EN is defined.
package seg_sched_pkg;

  localparam int NUM_SRC = 2;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Letter patterns, dp in bit 7.
  localparam logic [7:0] SEG_S = 8'h5B;
  localparam logic [7:0] SEG_E = 8'h4F;
  localparam logic [7:0] SEG_N = 8'h15;
  localparam logic [7:0] SEG_O = 8'h7E;
  localparam logic [7:0] SEG_L = 8'h0E;
  localparam logic [7:0] SEG_G = 8'h5F;
  localparam logic [7:0] SEG_U = 8'h3E;

`ifdef SEG_SCHED_BLANK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHOW, ST_BLANK} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHOW} state_t;
`endif

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_rr_arbiter.sv
// Two-way round-robin arbiter: one-hot grant from the request vector and the
// priority pointer; on load the pointer moves to the channel that did not win.
module seg_rr_arbiter
  import seg_sched_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic               ptr,
  input  logic               load,
  output logic [NUM_SRC-1:0] gnt,
  output logic               ptr_nxt
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    gnt     = req;
    ptr_nxt = ptr;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
    if (load) ptr_nxt = gnt[0];
  end

endmodule

// File: rtl/seg_display_sched.sv
// Round-robin, message-granular scheduler driving the 7-segment pad group.
// Define SEG_SCHED_BLANK_EN to insert a BLANK_CYCLES gap after every character.
module seg_display_sched
  import seg_sched_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       s0_valid,
  input  logic       s1_valid,
  input  logic [7:0] s0_seg,
  input  logic [7:0] s1_seg,
  input  logic       s0_last,
  input  logic       s1_last,
  output logic       s0_ready,
  output logic       s1_ready,
  output logic [7:0] seg_out,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int CNT_W = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
`ifdef SEG_SCHED_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               last_q;
  logic               ptr, ptr_nxt;
  logic [NUM_SRC-1:0] valids, arb_req, arb_gnt;
  logic               accept, complete, counting;
  logic [7:0]         acc_seg, seg_nxt;
  logic               acc_last, busy_nxt;
  logic [1:0]         grant_nxt;

  assign valids   = {s1_valid, s0_valid};
  // While a message is in flight the arbiter just echoes the held grant, so
  // its pointer update on completion names the other channel.
  assign arb_req  = (state == ST_IDLE) ? valids : grant;
  assign accept   = (state == ST_LOAD) && |(grant & valids);
  assign acc_seg  = grant[1] ? s1_seg : s0_seg;
  assign acc_last = grant[1] ? s1_last : s0_last;
  assign complete = (state != ST_IDLE) && (state_nxt == ST_IDLE);
  assign s0_ready = (state == ST_LOAD) && grant[0];
  assign s1_ready = (state == ST_LOAD) && grant[1];
`ifdef SEG_SCHED_BLANK_EN
  assign counting = (state == ST_SHOW) || (state == ST_BLANK);
`else
  assign counting = (state == ST_SHOW);
`endif

  seg_rr_arbiter u_arb (
    .req     (arb_req),
    .ptr     (ptr),
    .load    (complete),
    .gnt     (arb_gnt),
    .ptr_nxt (ptr_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      last_q  <= 1'b0;
      ptr     <= 1'b0;
      seg_out <= SEG_BLANK;
      grant   <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      seg_out <= seg_nxt;
      grant   <= grant_nxt;
      busy    <= busy_nxt;
      if (accept) last_q <= acc_last;
      if (state_nxt != state) cnt <= '0;
      else if (counting && tick_en) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|arb_gnt) state_nxt = ST_LOAD;
      ST_LOAD: if (accept) state_nxt = ST_SHOW;
      ST_SHOW:
        if (tick_en && cnt == DWELL_LAST) begin
`ifdef SEG_SCHED_BLANK_EN
          state_nxt = ST_BLANK;
`else
          state_nxt = last_q ? ST_IDLE : ST_LOAD;
`endif
        end
`ifdef SEG_SCHED_BLANK_EN
      ST_BLANK:
        if (tick_en && cnt == BLANK_LAST) state_nxt = last_q ? ST_IDLE : ST_LOAD;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs are computed one cycle ahead from the next state.
  always_comb begin
    seg_nxt   = SEG_BLANK;
    grant_nxt = grant;
    busy_nxt  = (state_nxt != ST_IDLE);
    if (state_nxt == ST_SHOW) seg_nxt = accept ? acc_seg : seg_out;
    if (state == ST_IDLE) grant_nxt = arb_gnt;
    else if (state_nxt == ST_IDLE) grant_nxt = '0;
  end

endmodule

// File: tb/tb_seg_display_sched.sv
// Directed scenarios for seg_display_sched with a display-order scoreboard.
// The blank-gap scenario runs only when SEG_SCHED_BLANK_EN is defined.
`timescale 1ns/1ps
module tb_seg_display_sched;
  import seg_sched_pkg::*;

  localparam int DWELL = 4;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst, tick_en;
  logic       s0_valid, s1_valid, s0_last, s1_last;
  logic [7:0] s0_seg, s1_seg, seg_out;
  logic       s0_ready, s1_ready, busy;
  logic [1:0] grant;

  seg_display_sched #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en),
    .s0_valid(s0_valid), .s1_valid(s1_valid),
    .s0_seg(s0_seg), .s1_seg(s1_seg),
    .s0_last(s0_last), .s1_last(s1_last),
    .s0_ready(s0_ready), .s1_ready(s1_ready),
    .seg_out(seg_out), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seg;
    logic [1:0] gnt;
    int         len;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [7:0] q0_seg[$], q1_seg[$];
  logic       q0_last[$], q1_last[$];
  int         errors = 0;
  int         checks = 0;
  int         exp_len = DWELL;
  int         tick_lo_from = -1;
  int         tick_lo_len = 0;
  logic [7:0] prev_seg;
  int         run_len;
  logic [7:0] trace_seg [0:63];
  logic       trace_r0  [0:63];
  logic       trace_r1  [0:63];
  logic       trace_busy[0:63];
  logic [1:0] trace_gnt [0:63];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_test();
    rst = 1'b1;
    q0_seg.delete(); q0_last.delete(); q1_seg.delete(); q1_last.delete();
    sb.delete();
    prev_seg = 8'h00;
    run_len = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push0(input logic [7:0] seg, input logic last);
    q0_seg.push_back(seg); q0_last.push_back(last);
  endtask

  task automatic push1(input logic [7:0] seg, input logic last);
    q1_seg.push_back(seg); q1_last.push_back(last);
  endtask

  // Drives both sources cycle by cycle from their queues; every accepted
  // character is pushed to the scoreboard and popped when it appears on seg_out.
  task automatic run_engine(input int budget, input logic [7:0] abort_seg, output int ncyc);
    int  c;
    bit  done;
    c = 0;
    done = 1'b0;
    while (!done) begin
      tick_en  = !(c >= tick_lo_from && c < tick_lo_from + tick_lo_len);
      s0_valid = (q0_seg.size() > 0);
      s0_seg   = s0_valid ? q0_seg[0] : 8'h00;
      s0_last  = s0_valid ? q0_last[0] : 1'b0;
      s1_valid = (q1_seg.size() > 0);
      s1_seg   = s1_valid ? q1_seg[0] : 8'h00;
      s1_last  = s1_valid ? q1_last[0] : 1'b0;
      if (c < 64) begin
        trace_seg[c] = seg_out; trace_r0[c] = s0_ready; trace_r1[c] = s1_ready;
        trace_busy[c] = busy; trace_gnt[c] = grant;
      end
      if (seg_out !== 8'h00 && seg_out !== prev_seg) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_char cycle %0d: got %h, required no character", c, seg_out);
        end else begin
          cur = sb.pop_front();
          if (seg_out !== cur.seg || grant !== cur.gnt) begin
            errors++;
            $display("FAIL char_order cycle %0d: got seg=%h grant=%b, required seg=%h grant=%b",
                     c, seg_out, grant, cur.seg, cur.gnt);
          end
        end
        run_len = 1;
      end else if (seg_out !== 8'h00) begin
        run_len++;
      end else if (prev_seg !== 8'h00) begin
        checks++;
        if (run_len != cur.len) begin
          errors++;
          $display("FAIL dwell_len cycle %0d: char %h shown %0d cycles, required %0d",
                   c, cur.seg, run_len, cur.len);
        end
      end
      prev_seg = seg_out;
      checks++;
      if ((s0_ready && grant !== 2'b01) || (s1_ready && grant !== 2'b10) || (s0_ready && s1_ready)) begin
        errors++;
        $display("FAIL ready_owner cycle %0d: ready=%b%b grant=%b, required ready only on granted channel",
                 c, s1_ready, s0_ready, grant);
      end
      if (s0_valid && s0_ready) begin
        sb.push_back('{seg: q0_seg[0], gnt: 2'b01, len: exp_len});
        void'(q0_seg.pop_front()); void'(q0_last.pop_front());
      end
      if (s1_valid && s1_ready) begin
        sb.push_back('{seg: q1_seg[0], gnt: 2'b10, len: exp_len});
        void'(q1_seg.pop_front()); void'(q1_last.pop_front());
      end
      if (abort_seg != 8'h00 && seg_out === abort_seg) begin
        done = 1'b1;
      end else if (c > 0 && q0_seg.size() == 0 && q1_seg.size() == 0 && sb.size() == 0 &&
                   busy === 1'b0 && prev_seg === 8'h00) begin
        done = 1'b1;
      end else if (c >= budget) begin
        checks++; errors++;
        $display("FAIL timeout: no completion within %0d cycles, busy=%b seg=%h", budget, busy, seg_out);
        done = 1'b1;
      end
      if (!done) begin
        @(negedge clk);
        c++;
      end
    end
    ncyc = c;
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (seg_out !== 8'h00 || grant !== 2'b00 || busy !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: seg=%h grant=%b busy=%b ready=%b%b, required all zero",
               tag, seg_out, grant, busy, s1_ready, s0_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick_en = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1; s0_seg = SEG_S; s1_seg = SEG_G;
    s0_last = 1'b0; s1_last = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset_state");
    checks++;
    if (seg_out !== SEG_BLANK) begin
      errors++;
      $display("FAIL reset_seg: got %h, required %h", seg_out, SEG_BLANK);
    end
  endtask

`ifndef SEG_SCHED_BLANK_EN
  task automatic test_single();
    int n;
    logic [7:0] es;
    start_test();
    push0(SEG_S, 1'b0); push0(SEG_E, 1'b1);
    run_engine(40, 8'h00, n);
    for (int c = 0; c <= 11; c++) begin
      es = (c >= 2 && c <= 5) ? SEG_S : (c >= 7 && c <= 10) ? SEG_E : 8'h00;
      checks++;
      if (trace_seg[c] !== es) begin
        errors++;
        $display("FAIL single_seg cycle %0d: got %h, required %h", c, trace_seg[c], es);
      end
      checks++;
      if (trace_r0[c] !== (c == 1 || c == 6)) begin
        errors++;
        $display("FAIL single_ready cycle %0d: got %b, required %b", c, trace_r0[c], (c == 1 || c == 6));
      end
    end
    checks++;
    if (n != 11 || trace_busy[11] !== 1'b0 || trace_gnt[11] !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: idle at cycle %0d busy=%b grant=%b, required cycle 11 busy=0 grant=00",
               n, trace_busy[11], trace_gnt[11]);
    end
  endtask
`else
  task automatic test_blank();
    int n;
    logic [7:0] es;
    start_test();
    push0(SEG_L, 1'b0); push0(SEG_L, 1'b1);
    run_engine(40, 8'h00, n);
    for (int c = 0; c <= 15; c++) begin
      es = ((c >= 2 && c <= 5) || (c >= 9 && c <= 12)) ? SEG_L : 8'h00;
      checks++;
      if (trace_seg[c] !== es) begin
        errors++;
        $display("FAIL blank_seg cycle %0d: got %h, required %h", c, trace_seg[c], es);
      end
    end
    checks++;
    if (n != 15 || trace_busy[7] !== 1'b1 || trace_busy[15] !== 1'b0 || trace_r0[8] !== 1'b1) begin
      errors++;
      $display("FAIL blank_timing: idle at %0d busy7=%b busy15=%b ready8=%b, required 15 1 0 1",
               n, trace_busy[7], trace_busy[15], trace_r0[8]);
    end
  endtask
`endif

  task automatic test_contention();
    int n;
    int first_r1;
`ifdef SEG_SCHED_BLANK_EN
    int exp_first = 2 + 2 * (1 + DWELL + BLANK);
`else
    int exp_first = 2 + 2 * (1 + DWELL);
`endif
    start_test();
    push0(SEG_S, 1'b0); push0(SEG_E, 1'b1);
    push1(SEG_G, 1'b0); push1(SEG_U, 1'b1);
    run_engine(60, 8'h00, n);
    first_r1 = -1;
    for (int c = 0; c < 64 && c <= n; c++)
      if (trace_r1[c] === 1'b1 && first_r1 < 0) first_r1 = c;
    checks++;
    if (trace_gnt[1] !== 2'b01) begin
      errors++;
      $display("FAIL contention_first: grant=%b, required 01", trace_gnt[1]);
    end
    checks++;
    if (first_r1 != exp_first) begin
      errors++;
      $display("FAIL contention_s1_ready: first at cycle %0d, required %0d", first_r1, exp_first);
    end
  endtask

  task automatic test_pointer();
    int n;
    push0(SEG_O, 1'b1); push1(SEG_N, 1'b1);
    run_engine(60, 8'h00, n);
    checks++;
    if (trace_gnt[1] !== 2'b01) begin
      errors++;
      $display("FAIL pointer_after_both: grant=%b, required 01", trace_gnt[1]);
    end
  endtask

  task automatic test_pause();
    int n;
    start_test();
    tick_lo_from = 3; tick_lo_len = 3; exp_len = 7;
    push0(SEG_O, 1'b1);
    run_engine(40, 8'h00, n);
    checks++;
    if (trace_seg[2] !== SEG_O || trace_seg[8] !== SEG_O || trace_seg[9] !== 8'h00) begin
      errors++;
      $display("FAIL pause_window: seg c2=%h c8=%h c9=%h, required %h %h 00",
               trace_seg[2], trace_seg[8], trace_seg[9], SEG_O, SEG_O);
    end
    tick_lo_from = -1; tick_lo_len = 0; exp_len = DWELL;
  endtask

  task automatic test_mid_reset();
    int n;
    start_test();
    push0(SEG_S, 1'b1);
    push1(SEG_G, 1'b0); push1(SEG_U, 1'b0); push1(SEG_E, 1'b1);
    run_engine(60, SEG_U, n);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("mid_reset");
    rst = 1'b0;
    q0_seg.delete(); q0_last.delete(); q1_seg.delete(); q1_last.delete();
    sb.delete();
    prev_seg = 8'h00;
    run_len = 0;
    push0(SEG_N, 1'b1);
    push1(SEG_G, 1'b0); push1(SEG_E, 1'b1);
    run_engine(60, 8'h00, n);
    checks++;
    if (trace_gnt[1] !== 2'b01) begin
      errors++;
      $display("FAIL mid_reset_pointer: grant=%b, required 01", trace_gnt[1]);
    end
  endtask

  initial begin
    test_reset();
`ifndef SEG_SCHED_BLANK_EN
    test_single();
`else
    test_blank();
`endif
    test_contention();
    test_pointer();
    test_pause();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
